// File: rtl/rf_sched_pkg.sv
// Shared encodings for the register-file access scheduler: control codes,
// source indices, FSM state and the register-file command payload.
package rf_sched_pkg;

    localparam int unsigned SRC_N     = 3;
    localparam int unsigned SRC_IDX_W = 2;
    localparam int unsigned ADDR_W    = 3;

    localparam logic [1:0] ENAB_IDLE = 2'b00;
    localparam logic [1:0] ENAB_WR   = 2'b01;
    localparam logic [1:0] ENAB_RD   = 2'b11;

    localparam logic [1:0] MUX_IMM = 2'b00;
    localparam logic [1:0] MUX_OR2 = 2'b10;
    localparam logic [1:0] MUX_ALU = 2'b11;

    localparam logic [SRC_IDX_W-1:0] SRC_IMM = 2'd0;
    localparam logic [SRC_IDX_W-1:0] SRC_OR2 = 2'd1;
    localparam logic [SRC_IDX_W-1:0] SRC_ALU = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_CMD  = 2'b01,
        ST_RD_DATA = 2'b10,
        ST_WR_CMD  = 2'b11
    } state_e;

    // Command presented to register1 each cycle
    typedef struct packed {
        logic [1:0]        enab;
        logic [1:0]        mux_sel;
        logic [ADDR_W-1:0] seg;
    } rf_ctrl_t;

    function automatic logic [1:0] mux_code(input logic [SRC_IDX_W-1:0] src);
        logic [1:0] code;
        case (src)
            SRC_OR2: code = MUX_OR2;
            SRC_ALU: code = MUX_ALU;
            default: code = MUX_IMM;
        endcase
        return code;
    endfunction

    function automatic logic [SRC_IDX_W-1:0] next_src(input logic [SRC_IDX_W-1:0] src);
        return (src >= SRC_ALU) ? SRC_IMM : src + SRC_IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker: first requester found scanning from ptr_i
// upward modulo 3. Purely combinational.
module rr_arb3
    import rf_sched_pkg::*;
(
    input  logic [SRC_N-1:0]     req_i,
    input  logic [SRC_IDX_W-1:0] ptr_i,
    output logic [SRC_N-1:0]     gnt_o,
    output logic [SRC_IDX_W-1:0] idx_o,
    output logic                 valid_o
);

    localparam int unsigned SUM_W = SRC_IDX_W + 1;

    function automatic logic [SRC_IDX_W-1:0] rot(input logic [SRC_IDX_W-1:0] p,
                                                input int unsigned        off);
        logic [SUM_W-1:0] s;
        s = {1'b0, p} + SUM_W'(off);
        if (s >= SUM_W'(SRC_N)) s = s - SUM_W'(SRC_N);
        return SRC_IDX_W'(s);
    endfunction

    logic                 found;
    logic [SRC_IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < SRC_N; i++) begin
            cand = rot(ptr_i, i);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rf_access_sched.sv
// Arbitrates one operand-fetch reader and three write-back sources onto the
// 8-entry register file, driving its enab/mux_sel/seg controls.
module rf_access_sched
    import rf_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned RAW_CHECK  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_gnt,
    output logic                      rd_valid,
    input  logic [SRC_N-1:0]          wr_req,
    input  logic [SRC_N*ADDR_W-1:0]   wr_addr,
    output logic [SRC_N-1:0]          wr_gnt,
    output logic [1:0]                enab,
    output logic [1:0]                mux_sel,
    output logic [ADDR_W-1:0]         seg,
    output logic                      busy
);

    localparam bit RAW_EN = (RAW_CHECK != 0);

    state_e               state_q, state_d;
    rf_ctrl_t             ctrl_q, ctrl_d;
    logic                 rd_gnt_q, rd_gnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [SRC_N-1:0]     wr_gnt_q, wr_gnt_d;
    logic                 busy_q, busy_d;
    logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic [ADDR_W-1:0]    src_addr [SRC_N];
    logic [SRC_N-1:0]     raw_req;
    logic [SRC_N-1:0]     raw_gnt, all_gnt, win_gnt;
    logic [SRC_IDX_W-1:0] raw_idx, all_idx, win_idx;
    logic                 raw_valid, all_valid;
    logic                 starve;
    logic                 win_wr, win_rd;

    // Unpack destinations and find writes that alias the pending read
    always_comb begin
        for (int unsigned k = 0; k < SRC_N; k++) begin
            src_addr[k] = wr_addr[k*ADDR_W +: ADDR_W];
            raw_req[k]  = RAW_EN && rd_req && wr_req[k] && (src_addr[k] == rd_addr);
        end
    end

    rr_arb3 u_arb_raw (
        .req_i   (raw_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (raw_gnt),
        .idx_o   (raw_idx),
        .valid_o (raw_valid)
    );

    rr_arb3 u_arb_all (
        .req_i   (wr_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (all_gnt),
        .idx_o   (all_idx),
        .valid_o (all_valid)
    );

    assign starve = (wait_cnt_q >= CNT_W'(STARVE_MAX));

    // Priority: RAW hazard, starved write, read, any write
    always_comb begin
        win_wr  = 1'b0;
        win_rd  = 1'b0;
        win_idx = all_idx;
        win_gnt = all_gnt;
        if (raw_valid) begin
            win_wr  = 1'b1;
            win_idx = raw_idx;
            win_gnt = raw_gnt;
        end else if (starve && all_valid) begin
            win_wr  = 1'b1;
        end else if (rd_req) begin
            win_rd  = 1'b1;
        end else if (all_valid) begin
            win_wr  = 1'b1;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        ctrl_d.enab  = ENAB_IDLE;
        rd_gnt_d     = 1'b0;
        rd_valid_d   = 1'b0;
        wr_gnt_d     = '0;
        rr_ptr_d     = rr_ptr_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_wr) begin
                    state_d        = ST_WR_CMD;
                    ctrl_d.enab    = ENAB_WR;
                    ctrl_d.seg     = src_addr[win_idx];
                    ctrl_d.mux_sel = mux_code(win_idx);
                    wr_gnt_d       = win_gnt;
                    rr_ptr_d       = next_src(win_idx);
                    wait_cnt_d     = '0;
                end else if (win_rd) begin
                    state_d     = ST_RD_CMD;
                    ctrl_d.enab = ENAB_RD;
                    ctrl_d.seg  = rd_addr;
                    rd_gnt_d    = 1'b1;
                    if ((|wr_req) && (wait_cnt_q != '1)) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RD_CMD: begin
                state_d    = ST_RD_DATA;
                rd_valid_d = 1'b1;
            end
            ST_RD_DATA: state_d = ST_IDLE;
            ST_WR_CMD:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_gnt_q   <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
            wr_gnt_q   <= wr_gnt_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign rd_gnt   = rd_gnt_q;
    assign rd_valid = rd_valid_q;
    assign wr_gnt   = wr_gnt_q;
    assign enab     = ctrl_q.enab;
    assign mux_sel  = ctrl_q.mux_sel;
    assign seg      = ctrl_q.seg;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rf_access_sched.sv
// Scoreboard bench for rf_access_sched: expected grants are queued with the
// stimulus and popped as grants appear; a small register-file model checks read data.
module tb_rf_access_sched;
    import rf_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rd_req, rd_req_b;
    logic [2:0] rd_addr, rd_addr_b;
    logic [2:0] wr_req, wr_req_b;
    logic [8:0] wr_addr, wr_addr_b;
    logic       rd_gnt, rd_valid, busy;
    logic [2:0] wr_gnt, seg;
    logic [1:0] enab, mux_sel;
    logic       rd_gnt_b, rd_valid_b, busy_b;
    logic [2:0] wr_gnt_b, seg_b;
    logic [1:0] enab_b, mux_sel_b;

    rf_access_sched #(.STARVE_MAX(4), .CNT_W(3), .RAW_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
        .enab(enab), .mux_sel(mux_sel), .seg(seg), .busy(busy)
    );

    rf_access_sched #(.STARVE_MAX(4), .CNT_W(3), .RAW_CHECK(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_gnt(rd_gnt_b), .rd_valid(rd_valid_b),
        .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_gnt(wr_gnt_b),
        .enab(enab_b), .mux_sel(mux_sel_b), .seg(seg_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_rd;
        int         src;
        logic [2:0] seg;
        logic [1:0] mux;
        int         dly;
        bit         chk;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    int         rd_hold  = 1;
    bit         valid_due = 1'b0;
    bit         chk_data  = 1'b0;
    logic [7:0] exp_data;
    logic [7:0] imm_d, or2_d, alu_d;
    logic [7:0] rf [8];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] wdata(input logic [1:0] m);
        case (m)
            MUX_IMM: return imm_d;
            MUX_OR2: return or2_d;
            MUX_ALU: return alu_d;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push(input bit is_rd, input int src, input logic [2:0] s, input logic [1:0] m,
                        input int dly, input bit chk, input logic [7:0] d);
        ev_t e;
        e.is_rd = is_rd; e.src = src; e.seg = s; e.mux = m; e.dly = dly; e.chk = chk; e.data = d;
        exp_q.push_back(e);
    endtask

    // One cycle: sample at negedge, score grants, model register1, retire requests
    task automatic tick();
        ev_t e;
        @(negedge clk);
        cyc++;
        check("rd_valid", 32'(rd_valid), 32'(valid_due));
        valid_due = 1'b0;
        check("one_gnt", 32'($countones({rd_gnt, wr_gnt}) <= 1), 32'd1);
        if (rd_valid && chk_data) check("rd_data", 32'(rf[seg]), 32'(exp_data));
        if (enab == ENAB_WR) rf[seg] = wdata(mux_sel);
        if (rd_gnt || (wr_gnt != 3'b000)) begin
            if (exp_q.size() == 0) begin
                check("spurious_gnt", 32'({rd_gnt, wr_gnt}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_rd", 32'(rd_gnt), 32'(e.is_rd));
                check("gnt_wr", 32'(wr_gnt), e.is_rd ? 32'd0 : 32'd1 << e.src);
                check("enab", 32'(enab), e.is_rd ? 32'(ENAB_RD) : 32'(ENAB_WR));
                check("seg", 32'(seg), 32'(e.seg));
                check("mux_sel", 32'(mux_sel), 32'(e.mux));
                check("busy", 32'(busy), 32'd1);
                if (e.dly > 0) check("latency", 32'(cyc - last_cyc), 32'(e.dly));
                last_cyc  = cyc;
                valid_due = e.is_rd;
                chk_data  = e.chk;
                exp_data  = e.data;
            end
            if (rd_gnt) begin
                if (rd_hold > 1) rd_hold--;
                else begin rd_req = 1'b0; rd_hold = 1; end
            end
            for (int k = 0; k < 3; k++) if (wr_gnt[k]) wr_req[k] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            check("drain_timeout", 32'(exp_q.size()) | 32'(busy), 32'd0);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enab"},     32'(enab),     32'd0);
        check({tag, "_mux_sel"},  32'(mux_sel),  32'd0);
        check({tag, "_seg"},      32'(seg),      32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_rd_gnt"},   32'(rd_gnt),   32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_wr_gnt"},   32'(wr_gnt),   32'd0);
        check({tag, "_b_enab"},   32'(enab_b),   32'd0);
        check({tag, "_b_busy"},   32'(busy_b),   32'd0);
    endtask

    task automatic start();
        last_cyc = cyc;
    endtask

    initial begin : main
        int rd_c, wr_c, t0;
        rst_n = 1'b0;
        rd_req = 1'b0; rd_addr = '0; wr_req = '0; wr_addr = '0;
        rd_req_b = 1'b0; rd_addr_b = '0; wr_req_b = '0; wr_addr_b = '0;
        imm_d = 8'h00; or2_d = 8'h00; alu_d = 8'h00;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;

        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Single OR2 write then read-back of the same register
        or2_d = 8'd6;
        wr_addr = {3'd0, 3'd7, 3'd0}; wr_req = 3'b010; start();
        push(0, 1, 3'd7, MUX_OR2, 1, 0, 8'h00);
        drain();
        rd_addr = 3'd7; rd_req = 1'b1; start();
        push(1, 0, 3'd7, MUX_OR2, 1, 1, 8'd6);
        drain();

        // Reset during RD_CMD abandons the read
        rd_addr = 3'd3; rd_req = 1'b1; start();
        push(1, 0, 3'd3, MUX_OR2, 1, 0, 8'h00);
        tick();
        rst_n = 1'b0;
        valid_due = 1'b0;
        #1;
        check("abort_enab", 32'(enab), 32'd0);
        tick();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        tick();

        // Round-robin across all three sources from rr_ptr=0
        imm_d = 8'h11; or2_d = 8'h22; alu_d = 8'h33;
        wr_addr = {3'd3, 3'd2, 3'd1}; wr_req = 3'b111; start();
        push(0, 0, 3'd1, MUX_IMM, 1, 0, 8'h00);
        push(0, 1, 3'd2, MUX_OR2, 2, 0, 8'h00);
        push(0, 2, 3'd3, MUX_ALU, 2, 0, 8'h00);
        drain();

        // RAW: aliasing ALU write goes before the read
        alu_d = 8'd7;
        wr_addr = {3'd2, 3'd0, 3'd0}; wr_req = 3'b100;
        rd_addr = 3'd2; rd_req = 1'b1; start();
        push(0, 2, 3'd2, MUX_ALU, 1, 0, 8'h00);
        push(1, 0, 3'd2, MUX_ALU, 2, 1, 8'd7);
        drain();

        // Move rr_ptr to OR2, then RAW with two aliasing writes and one unrelated
        imm_d = 8'h55;
        wr_addr = {3'd0, 3'd0, 3'd6}; wr_req = 3'b001; start();
        push(0, 0, 3'd6, MUX_IMM, 1, 0, 8'h00);
        drain();
        imm_d = 8'h44; or2_d = 8'h66; alu_d = 8'h77;
        wr_addr = {3'd4, 3'd5, 3'd4}; wr_req = 3'b111;
        rd_addr = 3'd4; rd_req = 1'b1; start();
        push(0, 2, 3'd4, MUX_ALU, 1, 0, 8'h00);
        push(0, 0, 3'd4, MUX_IMM, 2, 0, 8'h00);
        push(1, 0, 3'd4, MUX_IMM, 2, 1, 8'h44);
        push(0, 1, 3'd5, MUX_OR2, 3, 0, 8'h00);
        drain();
        check("rf5", 32'(rf[5]), 32'h66);

        // Starvation: four reads, then the waiting IMM write, then reads resume
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        imm_d = 8'h99;
        wr_addr = {3'd0, 3'd0, 3'd5}; wr_req = 3'b001;
        rd_addr = 3'd0; rd_req = 1'b1; rd_hold = 5; start();
        push(1, 0, 3'd0, MUX_IMM, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) push(1, 0, 3'd0, MUX_IMM, 3, 0, 8'h00);
        push(0, 0, 3'd5, MUX_IMM, 3, 0, 8'h00);
        push(1, 0, 3'd0, MUX_IMM, 2, 0, 8'h00);
        drain();
        check("starve_rd_dropped", 32'(rd_req), 32'd0);

        // RAW check disabled: read first, aliasing ALU write after it
        rd_addr_b = 3'd2; rd_req_b = 1'b1;
        wr_addr_b = {3'd2, 3'd0, 3'd0}; wr_req_b = 3'b100;
        t0 = cyc; rd_c = -1; wr_c = -1;
        for (int n = 0; n < 20 && (rd_c < 0 || wr_c < 0); n++) begin
            tick();
            if (rd_gnt_b) begin
                rd_c = cyc - t0;
                check("b_rd_seg", 32'(seg_b), 32'd2);
                check("b_rd_enab", 32'(enab_b), 32'(ENAB_RD));
                rd_req_b = 1'b0;
            end
            if (rd_valid_b) check("b_rd_valid_lat", 32'(cyc - t0), 32'd2);
            if (wr_gnt_b != 3'b000) begin
                wr_c = cyc - t0;
                check("b_wr_gnt", 32'(wr_gnt_b), 32'b100);
                check("b_wr_mux", 32'(mux_sel_b), 32'(MUX_ALU));
                wr_req_b = 3'b000;
            end
        end
        check("b_rd_lat", 32'(rd_c), 32'd1);
        check("b_wr_lat", 32'(wr_c), 32'd4);
        tick(); tick();
        check("b_idle", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
